// File: rtl/fetch_id_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_id_fifo_pkg
// Purpose  : Shared constants for the IF->ID fetch packet FIFO: NOP encoding,
//            packet width and the bit offsets used to pack/unpack a packet.
// Contents : INST_NOP, FETCH_PKT_W, OFF_* field offsets, idle_pkt()
// Revision : 1.0 - initial release
// ============================================================================
package fetch_id_fifo_pkg;

  // LoongArch canonical NOP (andi r0, r0, 0)
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  localparam int FETCH_PKT_W = 206;

  // Packet layout, LSB first
  localparam int OFF_PC0         = 0;
  localparam int OFF_PC1         = 32;
  localparam int OFF_PC_NEXT     = 64;
  localparam int OFF_INST0       = 96;
  localparam int OFF_INST1       = 128;
  localparam int OFF_BADV        = 160;
  localparam int OFF_PC_TAKEN    = 192;
  localparam int OFF_EXCP_FLAG   = 193;
  localparam int OFF_EXCEPTION   = 195;
  localparam int OFF_PRIV_FLAG   = 202;
  localparam int OFF_BRANCH_FLAG = 204;

  // Packet shown to ID whenever there is nothing valid to present
  function automatic logic [FETCH_PKT_W-1:0] idle_pkt();
    logic [FETCH_PKT_W-1:0] p;
    p = '0;
    p[OFF_INST0 +: 32] = INST_NOP;
    p[OFF_INST1 +: 32] = INST_NOP;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo_ram
// Purpose  : DEPTH x FETCH_PKT_W packet storage, one synchronous write port
//            and one asynchronous read port. Contents are not reset.
// Ports    : clk            - clock
//            we/waddr/wdata - write port
//            raddr/rdata    - combinational read port
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo_ram
  import fetch_id_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PTR_W-1:0]       waddr,
  input  logic [FETCH_PKT_W-1:0] wdata,
  input  logic [PTR_W-1:0]       raddr,
  output logic [FETCH_PKT_W-1:0] rdata
);

  logic [FETCH_PKT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_id_fifo
// Purpose  : Decoupling FIFO between instruction fetch and decode. Holds
//            dual-instruction fetch packets and presents the oldest one to ID
//            with the readygo/allowin handshake. Flush empties the FIFO.
// Ports    : aclk/aresetn  - clock, async active-low reset
//            flush         - discard all entries (wins over push/pop)
//            if_*          - incoming packet, valid on if_readygo
//            fifo_allowin  - ~full
//            id_readygo    - head valid, id_allowin consumes it
//            fifo_id_*     - head packet (NOP/0 when nothing valid)
//            fifo_count    - occupancy 0..DEPTH
// Options  : FETCH_FIFO_BYPASS_EN - when empty, an incoming packet is shown
//            to ID in the same cycle and skips storage if ID takes it.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_id_fifo
  import fetch_id_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             if_readygo,
  output logic             fifo_allowin,
  input  logic [31:0]      if_pc0,
  input  logic [31:0]      if_pc1,
  input  logic [31:0]      if_pc_next,
  input  logic             if_pc_taken,
  input  logic [31:0]      if_inst0,
  input  logic [31:0]      if_inst1,
  input  logic [31:0]      if_badv,
  input  logic [1:0]       if_excp_flag,
  input  logic [6:0]       if_exception,
  input  logic [1:0]       if_priv_flag,
  input  logic [1:0]       if_branch_flag,
  output logic             id_readygo,
  input  logic             id_allowin,
  output logic [31:0]      fifo_id_pc0,
  output logic [31:0]      fifo_id_pc1,
  output logic [31:0]      fifo_id_pc_next,
  output logic [31:0]      fifo_id_inst0,
  output logic [31:0]      fifo_id_inst1,
  output logic [31:0]      fifo_id_badv,
  output logic             fifo_id_pc_taken,
  output logic [1:0]       fifo_id_excp_flag,
  output logic [1:0]       fifo_id_priv_flag,
  output logic [1:0]       fifo_id_branch_flag,
  output logic [6:0]       fifo_id_exception,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  // Pointers carry one extra MSB as a wrap bit to separate full from empty
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic                   w_full, w_empty, w_push, w_push_mem, w_pop_mem, w_bypass;
  logic [FETCH_PKT_W-1:0] w_wdata, w_rdata, w_head;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign fifo_allowin = ~w_full;
  assign w_push       = if_readygo & fifo_allowin;

`ifdef FETCH_FIFO_BYPASS_EN
  // Incoming packet goes straight to ID; if taken it never enters storage
  assign w_bypass   = w_empty & ~flush & if_readygo;
  assign w_push_mem = w_push & ~(w_bypass & id_allowin);
`else
  assign w_bypass   = 1'b0;
  assign w_push_mem = w_push;
`endif

  // Only stored entries advance the read pointer; a bypassed packet does not
  assign w_pop_mem  = ~w_empty & id_allowin;
  assign id_readygo = ~w_empty | w_bypass;
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    w_wdata = '0;
    w_wdata[OFF_PC0         +: 32] = if_pc0;
    w_wdata[OFF_PC1         +: 32] = if_pc1;
    w_wdata[OFF_PC_NEXT     +: 32] = if_pc_next;
    w_wdata[OFF_INST0       +: 32] = if_inst0;
    w_wdata[OFF_INST1       +: 32] = if_inst1;
    w_wdata[OFF_BADV        +: 32] = if_badv;
    w_wdata[OFF_PC_TAKEN]          = if_pc_taken;
    w_wdata[OFF_EXCP_FLAG   +: 2]  = if_excp_flag;
    w_wdata[OFF_EXCEPTION   +: 7]  = if_exception;
    w_wdata[OFF_PRIV_FLAG   +: 2]  = if_priv_flag;
    w_wdata[OFF_BRANCH_FLAG +: 2]  = if_branch_flag;
  end

  // Flush overrides any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push_mem) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (w_pop_mem)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fetch_fifo_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (aclk),
    .we    (w_push_mem & ~flush),
    .waddr (wr_ptr_q[PTR_W-1:0]),
    .wdata (w_wdata),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (w_rdata)
  );

  // Head select: stored entry, else bypassed input, else idle NOP/0
  always_comb begin
    w_head = idle_pkt();
    if (!w_empty) begin
      w_head = w_rdata;
    end else if (w_bypass) begin
      w_head = w_wdata;
    end
  end

  assign fifo_id_pc0         = w_head[OFF_PC0         +: 32];
  assign fifo_id_pc1         = w_head[OFF_PC1         +: 32];
  assign fifo_id_pc_next     = w_head[OFF_PC_NEXT     +: 32];
  assign fifo_id_inst0       = w_head[OFF_INST0       +: 32];
  assign fifo_id_inst1       = w_head[OFF_INST1       +: 32];
  assign fifo_id_badv        = w_head[OFF_BADV        +: 32];
  assign fifo_id_pc_taken    = w_head[OFF_PC_TAKEN];
  assign fifo_id_excp_flag   = w_head[OFF_EXCP_FLAG   +: 2];
  assign fifo_id_exception   = w_head[OFF_EXCEPTION   +: 7];
  assign fifo_id_priv_flag   = w_head[OFF_PRIV_FLAG   +: 2];
  assign fifo_id_branch_flag = w_head[OFF_BRANCH_FLAG +: 2];

endmodule
`default_nettype wire

// File: tb/tb_fetch_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_id_fifo
// Purpose  : Self-checking bench for fetch_id_fifo: queue-based reference
//            model checked every cycle, directed scenarios with literal
//            expectations, then randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_id_fifo;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0340_0000;
`ifdef FETCH_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc0, pc1, pc_next, inst0, inst1, badv;
    logic        taken;
    logic [1:0]  excp;
    logic [6:0]  exc;
    logic [1:0]  priv, br;
  } pkt_t;

  logic aclk = 1'b0, aresetn = 1'b0, flush = 1'b0;
  logic if_readygo = 1'b0, id_allowin = 1'b0;
  pkt_t cur = '0;
  pkt_t idle;

  logic        fifo_allowin, id_readygo;
  logic [31:0] o_pc0, o_pc1, o_pcn, o_i0, o_i1, o_badv;
  logic        o_taken;
  logic [1:0]  o_excp, o_priv, o_br;
  logic [6:0]  o_exc;
  logic [3:0]  fifo_count;
  pkt_t        dut_pkt;

  int checks = 0, failures = 0;
  pkt_t q[$];

  always #5 aclk = ~aclk;

  fetch_id_fifo #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .if_readygo(if_readygo), .fifo_allowin(fifo_allowin),
    .if_pc0(cur.pc0), .if_pc1(cur.pc1), .if_pc_next(cur.pc_next),
    .if_pc_taken(cur.taken), .if_inst0(cur.inst0), .if_inst1(cur.inst1),
    .if_badv(cur.badv), .if_excp_flag(cur.excp), .if_exception(cur.exc),
    .if_priv_flag(cur.priv), .if_branch_flag(cur.br),
    .id_readygo(id_readygo), .id_allowin(id_allowin),
    .fifo_id_pc0(o_pc0), .fifo_id_pc1(o_pc1), .fifo_id_pc_next(o_pcn),
    .fifo_id_inst0(o_i0), .fifo_id_inst1(o_i1), .fifo_id_badv(o_badv),
    .fifo_id_pc_taken(o_taken), .fifo_id_excp_flag(o_excp),
    .fifo_id_priv_flag(o_priv), .fifo_id_branch_flag(o_br),
    .fifo_id_exception(o_exc), .fifo_count(fifo_count)
  );

  always_comb dut_pkt = {o_pc0, o_pc1, o_pcn, o_i0, o_i1, o_badv,
                         o_taken, o_excp, o_exc, o_priv, o_br};

  initial begin
    idle       = '0;
    idle.inst0 = NOP;
    idle.inst1 = NOP;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as an ordered queue of packets
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin : upd
      int n;
      bit byp, dpop, dpush;
      n     = q.size();
      byp   = BYP && (n == 0) && if_readygo;
      dpop  = (n != 0) && id_allowin;
      dpush = if_readygo && (n < DEPTH) && !(byp && id_allowin);
      if (dpop)  void'(q.pop_front());
      if (dpush) q.push_back(cur);
    end
  end

  // Per-cycle comparison, mid-cycle so inputs and outputs are settled
  always @(negedge aclk) begin
    if (aresetn) begin : cmp
      bit   byp_now;
      pkt_t exp_head;
      byp_now  = BYP && (q.size() == 0) && if_readygo && !flush;
      exp_head = (q.size() != 0) ? q[0] : (byp_now ? cur : idle);
      chk("readygo", id_readygo, (q.size() != 0) || byp_now);
      chk("allowin", fifo_allowin, q.size() < DEPTH);
      chk("count", fifo_count, q.size());
      chk("head", dut_pkt, exp_head);
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic pkt_t rand_pkt(input logic [31:0] pc);
    pkt_t p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         6'($urandom), $urandom, $urandom};
    p.pc0 = pc;
    return p;
  endfunction

  task automatic push_n(input int n, input logic [31:0] base, input logic allow);
    for (int i = 0; i < n; i++) begin
      cur        = rand_pkt(base + 32'(i * 8));
      if_readygo = 1'b1;
      id_allowin = allow;
      step();
    end
    if_readygo = 1'b0;
    id_allowin = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    chk("rst_readygo", id_readygo, 0);
    chk("rst_allowin", fifo_allowin, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_inst0", o_i0, NOP);
    chk("rst_pc0", o_pc0, 0);

    // Single packet, then pop
    cur        = rand_pkt(32'h1c00_0000);
    cur.inst0  = 32'h0280_0c21;
    if_readygo = 1'b1;
    step();
    if_readygo = 1'b0;
    #1;
    chk("single_readygo", id_readygo, 1);
    chk("single_pc0", o_pc0, 32'h1c00_0000);
    chk("single_inst0", o_i0, 32'h0280_0c21);
    id_allowin = 1'b1;
    step();
    id_allowin = 1'b0;
    chk("single_pop_readygo", id_readygo, 0);
    chk("single_pop_inst0", o_i0, NOP);
    chk("single_pop_pc0", o_pc0, 0);

    // Fill to full, overflow attempt, drain
    push_n(DEPTH, 32'h1c00_1000, 1'b0);
    chk("full_count", fifo_count, 8);
    chk("full_allowin", fifo_allowin, 0);
    push_n(1, 32'h1c00_dead, 1'b0);
    chk("full_drop_count", fifo_count, 8);
    chk("full_head_pc0", o_pc0, 32'h1c00_1000);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc0", o_pc0, 32'h1c00_1000 + 32'(i * 8));
      id_allowin = 1'b1;
      step();
    end
    id_allowin = 1'b0;
    chk("drain_count", fifo_count, 0);

    // Steady push+pop at count 4 across pointer wrap
    push_n(4, 32'h1c00_2000, 1'b0);
    push_n(20, 32'h1c00_2020, 1'b1);
    chk("pp_count", fifo_count, 4);
    chk("pp_head_pc0", o_pc0, 32'h1c00_2000 + 32'(20 * 8));

    // Flush at count 5 with concurrent push and pop
    push_n(1, 32'h1c00_3000, 1'b0);
    cur        = rand_pkt(32'h1c00_beef);
    flush      = 1'b1;
    if_readygo = 1'b1;
    id_allowin = 1'b1;
    step();
    flush      = 1'b0;
    if_readygo = 1'b0;
    id_allowin = 1'b0;
    chk("flush_count", fifo_count, 0);
    chk("flush_readygo", id_readygo, 0);

    // Same-cycle presentation of an incoming packet to an empty FIFO
    cur        = rand_pkt(32'h1c00_0100);
    if_readygo = 1'b1;
    id_allowin = 1'b1;
    #1;
    chk("byp_readygo", id_readygo, BYP);
    chk("byp_pc0", o_pc0, BYP ? 32'h1c00_0100 : 32'h0);
    step();
    if_readygo = 1'b0;
    id_allowin = 1'b0;
    chk("byp_next_count", fifo_count, BYP ? 0 : 1);
    chk("byp_next_readygo", id_readygo, !BYP);
    id_allowin = 1'b1;
    step();
    id_allowin = 1'b0;

    // Asynchronous reset in mid-cycle with 3 packets held
    push_n(3, 32'h1c00_4000, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_readygo", id_readygo, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_inst0", o_i0, NOP);
    aresetn = 1'b1;
    push_n(1, 32'h1c00_0200, 1'b0);
    chk("arst_push_count", fifo_count, 1);
    chk("arst_push_pc0", o_pc0, 32'h1c00_0200);

    // Randomized traffic, alternating drain bias so full and empty both occur
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 400; c++) begin
        cur        = rand_pkt($urandom);
        if_readygo = ($urandom_range(0, 3) != 0);
        id_allowin = (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    flush      = 1'b0;
    if_readygo = 1'b0;
    id_allowin = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_id_fifo.md
Name: fetch_id_fifo

Overview:
- Decoupling buffer between instruction fetch (IF) and decode (ID).
- Stores dual-instruction fetch packets: PCs, instructions, predicted next PC, bad-address and exception info, privilege flags and branch flags.
- Presents the oldest packet to ID on the fifo_id_* bus, using the readygo/allowin handshake.
- Flush clears all contents. IF keeps fetching while ID stalls.

Parameters:
- DEPTH, 8, number of packet entries; must be a power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- flush  in  1  discard all entries; from backend redirect
- if_readygo  in  1  IF packet valid this cycle
- fifo_allowin  out  1  FIFO can accept a packet; equals ~full
- if_pc0, if_pc1, if_pc_next  in  32 each  packet PCs and predicted next PC
- if_pc_taken  in  1  prediction taken
- if_inst0, if_inst1  in  32 each  instructions
- if_badv  in  32  faulting address
- if_excp_flag  in  2  per-slot exception valid
- if_exception  in  7  exception code
- if_priv_flag  in  2  per-slot privileged
- if_branch_flag  in  2  per-slot branch
- id_readygo  out  1  head packet valid; equals ~empty
- id_allowin  in  1  ID consumes the head this cycle when id_readygo=1
- fifo_id_pc0, fifo_id_pc1, fifo_id_pc_next, fifo_id_inst0, fifo_id_inst1, fifo_id_badv  out  32 each  head packet fields
- fifo_id_pc_taken  out  1  head packet field
- fifo_id_excp_flag, fifo_id_priv_flag, fifo_id_branch_flag  out  2 each  head packet fields
- fifo_id_exception  out  7  head packet field
- fifo_count  out  PTR_W+1  occupancy

Behaviour:
- Storage: DEPTH x 206-bit packet array; wr_ptr and rd_ptr are PTR_W+1 bits, with the MSB used as the wrap bit.
- Definitions:
  - push = if_readygo & fifo_allowin
  - pop = id_readygo & id_allowin
  - full = (ptr MSBs differ) & (lower bits equal)
  - empty = (wr_ptr == rd_ptr)
- Reset (aresetn=0, async):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs: id_readygo=0, fifo_allowin=1, fifo_count=0.
  - fifo_id_inst0/1 = INST_NOP; all other fifo_id_* = 0.
  - The packet array is not reset.
- Priority order: flush > push/pop. While flush=1 at a clock edge:
  - pointers and count clear;
  - the push in the same cycle is dropped;
  - pop is ignored.
- Push writes entry[wr_ptr[PTR_W-1:0]], then increments wr_ptr.
- Pop increments rd_ptr.
- Push and pop together: count is unchanged; both pointers advance.
- Full: fifo_allowin=0, so a push is refused even if a pop occurs in the same cycle (fifo_allowin is a function of occupancy only).
- Empty: id_readygo=0. fifo_id_* are forced to the reset values (NOP/0) so ID never sees stale data.
- Latency: a packet pushed at edge N is visible on fifo_id_* with id_readygo=1 after edge N (i.e. in cycle N+1); no combinational path from if_* to fifo_id_*.
- Head outputs are a combinational read of entry[rd_ptr]. They stay stable while id_allowin=0.
- Pointer wrap: after entry DEPTH-1, the low bits return to 0 and the MSB toggles.
- fifo_count = wr_ptr - rd_ptr (modulo 2^(PTR_W+1)). It ranges 0..DEPTH.
- Ordering is strictly FIFO; packets are never reordered or merged.

Optional Feature:
- Macro: FETCH_FIFO_BYPASS_EN.
- With the macro:
  - When empty, not flushing, and if_readygo=1, the if_* fields drive fifo_id_* combinationally and id_readygo=1 in that cycle.
  - If id_allowin=1 in that cycle, the packet is consumed and not written, so pointers are unchanged.
  - Otherwise the packet is written normally.
- Without the macro: minimum latency is one cycle, as stated above.

Decomposition:
- Shared package/defines holds:
  - INST_NOP;
  - FETCH_PKT_W = 206;
  - field offset constants for packing and unpacking the packet vector.
- Sub-module fetch_fifo_ram: DEPTH x FETCH_PKT_W array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, flag and handshake logic stay in fetch_id_fifo.

Test Plan:
- Reset mid-operation: fill 3 packets, pulse aresetn low asynchronously between edges -> immediately id_readygo=0, fifo_count=0, fifo_id_inst0=INST_NOP; the next push after release appears at entry 0.
- Single packet: push pc0=0x1c000000, inst0=0x02800c21 at edge N -> at N+1 id_readygo=1 and fifo_id_pc0=0x1c000000; pop with id_allowin=1 -> empty, outputs NOP/0.
- Fill to full (DEPTH=8): push 8 packets with id_allowin=0 -> fifo_allowin=0, fifo_count=8; a 9th push with if_readygo=1 is dropped; drain 8 packets -> pc0 values appear in push order.
- Simultaneous push/pop at count=4 for 20 cycles -> count stays 4; pointers wrap without data loss; pc sequence is contiguous.
- Flush with concurrent push and pop at count=5 -> count=0, id_readygo=0 next cycle; the pushed packet never appears.
- FETCH_FIFO_BYPASS_EN build: empty FIFO, if_readygo=1 and id_allowin=1 -> fifo_id_pc0 equals if_pc0 in the same cycle, fifo_count stays 0. Non-bypass build: same stimulus -> id_readygo=0 that cycle, 1 the next.
